// File: rtl/tasten_auswertung_pkg.sv
// Shared definitions for the button press classifier: state encoding,
// default 50 MHz timing constants and a small constant helper.
package tasten_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_WAIT2  = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_HELD   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        PRESS1 = ST_PRESS1,
        WAIT2  = ST_WAIT2,
        PRESS2 = ST_PRESS2,
        HELD   = ST_HELD
    } state_t;

    localparam int LONG_COUNT_DEF   = 50_000_000;
    localparam int DOUBLE_GAP_DEF   = 15_000_000;
    localparam int REPEAT_COUNT_DEF = 10_000_000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/tasten_auswertung_if.sv
// Button level in, one-cycle classification events out.
// slave = classifier side, master = level source / event consumer.
interface tasten_auswertung_if;

    logic entprellt;
    logic kurz;
    logic doppel;
    logic lang;
    logic wiederholt;
    logic aktiv;

    modport slave (
        input  entprellt,
        output kurz,
        output doppel,
        output lang,
        output wiederholt,
        output aktiv
    );

    modport master (
        output entprellt,
        input  kurz,
        input  doppel,
        input  lang,
        input  wiederholt,
        input  aktiv
    );

endinterface

// File: rtl/tasten_auswertung_flanken_erkennung.sv
// Rise/fall detector on the debounced level using a one-flop history.
// History resets to 0 so a level held through reset counts as a rise.
module flanken_erkennung (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/tasten_auswertung.sv
// Press classifier: turns the debounced level into kurz/doppel/lang pulses.
// Optional auto-repeat while held after a long press: `define TASTEN_REPEAT_EN.
module tasten_auswertung
    import tasten_pkg::*;
#(
    parameter int LONG_COUNT   = LONG_COUNT_DEF,
    parameter int DOUBLE_GAP   = DOUBLE_GAP_DEF,
    parameter int REPEAT_COUNT = REPEAT_COUNT_DEF
) (
    input logic                 clk,
    input logic                 rst,
    tasten_auswertung_if.slave  bus
);

    localparam int MAX_CNT = max3(LONG_COUNT, DOUBLE_GAP, REPEAT_COUNT);
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_COUNT - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(DOUBLE_GAP - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(MAX_CNT);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic             rise;
    logic             fall;
    logic             kurz_n;
    logic             doppel_n;
    logic             lang_n;
    logic             rep_n;

    flanken_erkennung u_flanken (
        .clk   (clk),
        .rst   (rst),
        .level (bus.entprellt),
        .rise  (rise),
        .fall  (fall)
    );

`ifdef TASTEN_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_TERM = CNT_W'(REPEAT_COUNT - 1);
`endif

    // Level edges are checked before counter expiry so an edge always wins.
    always_comb begin
        state_n  = state;
        kurz_n   = 1'b0;
        doppel_n = 1'b0;
        lang_n   = 1'b0;
        rep_n    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) state_n = PRESS1;
            end
            PRESS1: begin
                if (fall) begin
                    state_n = WAIT2;
                end else if (cnt == LONG_TERM) begin
                    lang_n  = 1'b1;
                    state_n = HELD;
                end
            end
            WAIT2: begin
                if (rise) begin
                    state_n = PRESS2;
                end else if (cnt == GAP_TERM) begin
                    kurz_n  = 1'b1;
                    state_n = IDLE;
                end
            end
            PRESS2: begin
                if (fall) begin
                    doppel_n = 1'b1;
                    state_n  = IDLE;
                end
            end
            HELD: begin
                if (fall) begin
                    state_n = IDLE;
                end
`ifdef TASTEN_REPEAT_EN
                else if (cnt == REP_TERM) begin
                    rep_n = 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // A repeat pulse restarts the HELD period just like a state change.
    assign cnt_clr = (state_n != state) | rep_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            bus.kurz   <= 1'b0;
            bus.doppel <= 1'b0;
            bus.lang   <= 1'b0;
            bus.aktiv  <= 1'b0;
        end else begin
            state      <= state_n;
            bus.kurz   <= kurz_n;
            bus.doppel <= doppel_n;
            bus.lang   <= lang_n;
            bus.aktiv  <= (state_n != IDLE);
        end
    end

    // Saturating cycle counter; PRESS2 may be held arbitrarily long.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt_clr) begin
            cnt <= '0;
        end else if (state != IDLE && cnt != CNT_SAT) begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef TASTEN_REPEAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.wiederholt <= 1'b0;
        end else begin
            bus.wiederholt <= rep_n;
        end
    end
`else
    assign bus.wiederholt = 1'b0;
`endif

endmodule
